// File: rtl/sig_gen16x64x64_pkg.sv
// Shared definitions for the 16-channel pattern generator: FSM encodings and size defaults.
package sig_gen16x64x64_pkg;

   localparam int DEF_NUM_CH       = 16;
   localparam int DEF_DATA_WIDTH   = 64;
   localparam int DEF_ADDR_WIDTH   = 6;
   localparam int DEF_CH_SEL_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      PLAY  = 2'b10,
      DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/sig_gen16x64x64_mem.sv
// Single-port-write, synchronous-read pattern RAM; the array is never reset.
module play_mem64x64 #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= din;
      if (rd_en)
         dout <= mem[rd_addr];
   end

endmodule

// File: rtl/sig_gen16x64x64.sv
// 16-channel pattern generator: load pattern RAMs, arm, then replay words 0..last_addr on trigger.
module sig_gen16x64x64
   import sig_gen16x64x64_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int CH_SEL_WIDTH = DEF_CH_SEL_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_en,
   input  logic [CH_SEL_WIDTH-1:0]      ld_chip_sel,
   input  logic [ADDR_WIDTH-1:0]        ld_addr,
   input  logic [DATA_WIDTH-1:0]        ld_data,
   output logic                         ld_err,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         loop_en,
   input  logic [ADDR_WIDTH-1:0]        last_addr,
   input  logic                         trigger,
   output logic [NUM_CH*DATA_WIDTH-1:0] dout,
   output logic                         dout_valid,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH-1:0]        play_addr,
   output logic [1:0]                   state
);

   state_t                         st;
   logic [ADDR_WIDTH-1:0]          play_addr_q;
   logic [ADDR_WIDTH-1:0]          last_q;
   logic                           loop_q;
   logic                           done_q;
   logic                           ld_err_q;
   logic                           load_ok;
   logic                           rd_en;
   logic                           vld_p1;
   logic                           vld_p2;
   logic [NUM_CH*DATA_WIDTH-1:0]   rd_flat_p1;
   logic [NUM_CH*DATA_WIDTH-1:0]   dout_p2;

   assign load_ok = (st == IDLE) || (st == DONE);
   assign rd_en   = (st == PLAY);

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         logic [DATA_WIDTH-1:0] rd_data_p1;
         play_mem64x64 #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_mem (
            .clk     (clk),
            .din     (ld_data),
            .wr_addr (ld_addr),
            .wr_en   (ld_en && (ld_chip_sel == CH_SEL_WIDTH'(i)) && load_ok),
            .rd_addr (play_addr_q),
            .rd_en   (rd_en),
            .dout    (rd_data_p1)
         );
         assign rd_flat_p1[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_p1;
      end
   endgenerate

   // Control FSM; done waits for the read pipeline to drain before rising
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st          <= IDLE;
         play_addr_q <= '0;
         last_q      <= '0;
         loop_q      <= 1'b0;
         done_q      <= 1'b0;
         ld_err_q    <= 1'b0;
      end else begin
         ld_err_q <= ld_en && !load_ok;
         if (abort) begin
            st          <= IDLE;
            play_addr_q <= '0;
            done_q      <= 1'b0;
         end else begin
            unique case (st)
               IDLE: begin
                  if (arm) begin
                     st     <= ARMED;
                     last_q <= last_addr;
                     loop_q <= loop_en;
                  end
               end
               ARMED: begin
                  if (trigger) begin
                     st          <= PLAY;
                     play_addr_q <= '0;
                  end
               end
               PLAY: begin
                  if (play_addr_q == last_q) begin
                     if (loop_q)
                        play_addr_q <= '0;
                     else
                        st <= DONE;
                  end else begin
                     play_addr_q <= play_addr_q + ADDR_WIDTH'(1);
                  end
               end
               DONE: begin
                  if (arm) begin
                     st     <= ARMED;
                     last_q <= last_addr;
                     loop_q <= loop_en;
                     done_q <= 1'b0;
                  end else if (!vld_p1) begin
                     done_q <= 1'b1;
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   // Stage 1 -> stage 2: RAM read data registered onto dout, zeroed when not valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         dout_p2 <= '0;
      end else if (abort) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         dout_p2 <= '0;
      end else begin
         vld_p1  <= (st == PLAY);
         vld_p2  <= vld_p1;
         dout_p2 <= vld_p1 ? rd_flat_p1 : '0;
      end
   end

   assign dout       = dout_p2;
   assign dout_valid = vld_p2;
   assign busy       = (st == ARMED) || (st == PLAY);
   assign done       = done_q;
   assign ld_err     = ld_err_q;
   assign play_addr  = play_addr_q;
   assign state      = st;

endmodule

// File: tb/tb_sig_gen16x64x64.sv
// Directed bench for sig_gen16x64x64: load, one-shot, loop, rejection, precedence, boundary, async reset.
module tb_sig_gen16x64x64;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_en;
   logic [3:0]    ld_chip_sel;
   logic [5:0]    ld_addr;
   logic [63:0]   ld_data;
   logic          ld_err;
   logic          arm;
   logic          abort;
   logic          loop_en;
   logic [5:0]    last_addr;
   logic          trigger;
   logic [1023:0] dout;
   logic          dout_valid;
   logic          busy;
   logic          done;
   logic [5:0]    play_addr;
   logic [1:0]    state;

   int errors = 0;
   int checks = 0;

   sig_gen16x64x64 dut (
      .clk         (clk),
      .rst         (rst),
      .ld_en       (ld_en),
      .ld_chip_sel (ld_chip_sel),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_err      (ld_err),
      .arm         (arm),
      .abort       (abort),
      .loop_en     (loop_en),
      .last_addr   (last_addr),
      .trigger     (trigger),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .busy        (busy),
      .done        (done),
      .play_addr   (play_addr),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int ch, input int a);
      return {32'(ch), 32'(a)};
   endfunction

   function automatic logic [63:0] chan(input logic [1023:0] d, input int ch);
      return d[ch*64 +: 64];
   endfunction

   initial begin
      rst = 1'b0; ld_en = 1'b0; ld_chip_sel = '0; ld_addr = '0; ld_data = '0;
      arm = 1'b0; abort = 1'b0; loop_en = 1'b0; last_addr = '0; trigger = 1'b0;
      tick(); tick();
      chk("rst_state", state, 2'b00);
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ld_err", ld_err, 1'b0);
      chk("rst_play_addr", play_addr, 6'd0);
      chk("rst_dout_zero", (dout === '0), 1'b1);
      rst = 1'b1;
      tick();

      // Fill every channel/word with {ch, addr}
      for (int c = 0; c < 16; c++) begin
         for (int a = 0; a < 64; a++) begin
            ld_en = 1'b1; ld_chip_sel = 4'(c); ld_addr = 6'(a); ld_data = pat(c, a);
            tick();
         end
      end
      ld_en = 1'b0;
      chk("load_no_err", ld_err, 1'b0);
      chk("load_state_idle", state, 2'b00);

      // Trigger in IDLE is ignored
      trigger = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_trig_valid", dout_valid, 1'b0);
      end
      chk("idle_trig_state", state, 2'b00);
      trigger = 1'b0;

      // One-shot playback of 64 words
      last_addr = 6'd63; loop_en = 1'b0; arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("arm_state", state, 2'b01);
      chk("arm_busy", busy, 1'b1);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("trig_state", state, 2'b10);
      chk("trig_addr0", play_addr, 6'd0);
      tick();
      chk("lat_valid_low", dout_valid, 1'b0);
      for (int a = 0; a < 64; a++) begin
         tick();
         chk("full_valid", dout_valid, 1'b1);
         for (int c = 0; c < 16; c++)
            chk("full_word", chan(dout, c), pat(c, a));
         if (a == 61) chk("full_busy_play", busy, 1'b1);
         if (a == 62) begin
            chk("full_busy_drain", busy, 1'b0);
            chk("full_state_drain", state, 2'b11);
            chk("full_done_drain", done, 1'b0);
         end
      end
      tick();
      chk("full_end_valid", dout_valid, 1'b0);
      chk("full_end_done", done, 1'b1);
      chk("full_end_state", state, 2'b11);
      chk("full_end_dout", (dout === '0), 1'b1);

      // Looping playback, last_addr=3; later input changes ignored; load rejected in PLAY
      last_addr = 6'd3; loop_en = 1'b1; arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("rearm_done", done, 1'b0);
      chk("rearm_busy", busy, 1'b1);
      chk("rearm_state", state, 2'b01);
      last_addr = 6'd9; loop_en = 1'b0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("loop_valid", dout_valid, 1'b1);
         chk("loop_ch5", chan(dout, 5), pat(5, k % 4));
         chk("loop_ch2", chan(dout, 2), pat(2, k % 4));
         if (k == 5) begin
            ld_en = 1'b1; ld_chip_sel = 4'd2; ld_addr = 6'd0; ld_data = 64'hDEAD;
         end
         if (k == 6) begin
            ld_en = 1'b0;
            chk("ld_err_pulse", ld_err, 1'b1);
         end
         if (k == 7) chk("ld_err_clear", ld_err, 1'b0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", dout_valid, 1'b0);
      chk("abort_state", state, 2'b00);
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_dout", (dout === '0), 1'b1);

      // Abort beats trigger in the same cycle
      arm = 1'b1;
      tick();
      arm = 1'b0;
      trigger = 1'b1; abort = 1'b1;
      tick();
      trigger = 1'b0; abort = 1'b0;
      chk("prec_state", state, 2'b00);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("prec_valid", dout_valid, 1'b0);
      end

      // Single-word pattern; last_addr changed after arm must not matter
      last_addr = 6'd0; loop_en = 1'b0; arm = 1'b1;
      tick();
      arm = 1'b0;
      last_addr = 6'd7;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      chk("one_lat_valid", dout_valid, 1'b0);
      tick();
      chk("one_valid", dout_valid, 1'b1);
      chk("one_ch2", chan(dout, 2), pat(2, 0));
      chk("one_ch9", chan(dout, 9), pat(9, 0));
      tick();
      chk("one_end_valid", dout_valid, 1'b0);
      chk("one_end_done", done, 1'b1);
      chk("one_end_state", state, 2'b11);
      chk("one_end_dout", (dout === '0), 1'b1);
      tick();
      chk("one_after_valid", dout_valid, 1'b0);

      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("done_rearm_done", done, 1'b0);
      chk("done_rearm_busy", busy, 1'b1);

      // Async reset mid-PLAY, between clock edges
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick(); tick();
      chk("pre_rst_valid", dout_valid, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_state", state, 2'b00);
      chk("arst_valid", dout_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_play_addr", play_addr, 6'd0);
      chk("arst_dout", (dout === '0), 1'b1);
      tick();
      rst = 1'b1;
      trigger = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_valid", dout_valid, 1'b0);
         chk("post_rst_state", state, 2'b00);
      end
      trigger = 1'b0;
      last_addr = 6'd1; loop_en = 1'b0; arm = 1'b1;
      tick();
      arm = 1'b0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      tick();
      chk("post_rst_play_valid", dout_valid, 1'b1);
      chk("post_rst_play_ch7", chan(dout, 7), pat(7, 0));
      tick();
      chk("post_rst_play_ch7_w1", chan(dout, 7), pat(7, 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sig_gen16x64x64.md
Name: sig_gen16x64x64

Overview:
- Pattern generator: the playback counterpart of the 16-channel 64x64 capture analyzer.
- Control logic loads 16 independent 64-word x 64-bit pattern memories through a simple load port, then arms the block.
- On trigger the block replays words 0..last_addr on all 16 channel outputs simultaneously, one word per clock, once or looping.
- Sits between the register-decode logic (load/arm/abort strobes) and the device under test.

Parameters:
- NUM_CH, 16, number of channels/pattern memories.
- DATA_WIDTH, 64, bits per channel word.
- ADDR_WIDTH, 6, memory address width (depth 2**ADDR_WIDTH = 64).
- CH_SEL_WIDTH, 4, width of the channel select for loads.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  load strobe, one word per cycle.
- ld_chip_sel  in  CH_SEL_WIDTH  target channel memory.
- ld_addr  in  ADDR_WIDTH  target word address.
- ld_data  in  DATA_WIDTH  word to store.
- ld_err  out  1  one-cycle pulse when a load is rejected.
- arm  in  1  pulse; arms playback, samples loop_en and last_addr.
- abort  in  1  pulse; returns to IDLE from any state.
- loop_en  in  1  1 = wrap to address 0 after last_addr.
- last_addr  in  ADDR_WIDTH  final address of the pattern (length = last_addr+1).
- trigger  in  1  level; starts playback when ARMED.
- dout  out  NUM_CH*DATA_WIDTH  channel i on bits [i*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  out  1  dout carries a pattern word.
- busy  out  1  state is ARMED or PLAY.
- done  out  1  non-loop playback completed.
- play_addr  out  ADDR_WIDTH  address currently issued to the memories.
- state  out  2  00 IDLE, 01 ARMED, 10 PLAY, 11 DONE.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state=IDLE and play_addr=0.
  - dout=0, dout_valid=0, busy=0, done=0, ld_err=0.
  - Internal pipeline valid bits cleared.
  - Memory contents are not reset (undefined until loaded).
- Reset applied mid-PLAY clears everything immediately; no further valid words are emitted.
- Loads:
  - Accepted only in IDLE or DONE. An accepted write takes effect at the next edge.
  - ld_en in ARMED or PLAY: the memory is not written and ld_err pulses high for exactly one cycle.
  - Loads never change state.
- FSM transitions:
  - IDLE --arm--> ARMED. DONE --arm--> ARMED; done clears at the same edge.
  - At the arm edge, loop_en and last_addr are captured into internal registers. Later changes to these inputs are ignored until the next arm.
  - ARMED --trigger--> PLAY, with play_addr=0. Trigger in IDLE, PLAY or DONE is ignored. Arm in ARMED or PLAY is ignored.
  - PLAY: play_addr increments by 1 each cycle.
  - At play_addr==captured last_addr:
    - loop=1: play_addr wraps to 0 next cycle, with no gap.
    - loop=0: go to DONE.
  - last_addr=0 is legal: a single-word pattern, or the same word repeated when looping.
  - abort in any state --> IDLE next edge; play_addr=0, pipeline valid bits flushed, dout_valid=0 from the next cycle.
  - Precedence: abort > arm/trigger. abort and trigger in the same cycle -> IDLE.
- Pipeline (latency 2):
  - Stage 1: synchronous memory read at play_addr.
  - Stage 2: registered dout/dout_valid.
  - Trigger sampled high at edge T -> word 0 appears on dout with dout_valid=1 in the cycle following edge T+2.
  - Subsequent words follow on consecutive cycles.
- dout is 0 whenever dout_valid=0.
- done rises in the first cycle after the last valid word (dout_valid falling) and holds until arm or abort.
- busy=1 in ARMED and PLAY. busy falls on entry to DONE even while the last words are still draining.
- Address arithmetic is modulo 2**ADDR_WIDTH; there is no overflow flag.

Decomposition:
- Shared package holds:
  - state encodings IDLE/ARMED/PLAY/DONE;
  - NUM_CH, DATA_WIDTH, ADDR_WIDTH, CH_SEL_WIDTH defaults.
- One sub-module, play_mem64x64: single-port write, sync-read 64x64 RAM, no reset on the array.
  - Ports: din, wr_addr, wr_en, rd_addr, rd_en, clk, dout.
  - Instantiated NUM_CH times via generate.
  - Write enable per instance is ld_en && (ld_chip_sel==i) && load_allowed.

Test Plan:
- Load sequence: load channel i word a = {i,a} pattern for all 16x64 words; arm with last_addr=63, loop_en=0; trigger -> dout_valid high for exactly 64 cycles starting 2 cycles after the trigger edge. Each cycle, channel i shows {i,a} for a=0..63. Then done=1, state=11, dout=0.
- Looping: last_addr=3, loop_en=1, trigger -> channel 5 sequence {5,0},{5,1},{5,2},{5,3},{5,0}... with no gaps for 20 cycles. Then abort -> dout_valid=0 one cycle later, state=00, done=0.
- Load rejection: ld_en with data 0xDEAD written to ch 2 addr 0 while PLAY -> ld_err pulses once. Replay shows the original word, not 0xDEAD.
- Precedence: trigger and abort asserted in the same cycle while ARMED -> state=IDLE, dout_valid never rises. Trigger held high in IDLE -> no playback.
- Boundary: last_addr=0, loop_en=0 -> exactly one valid word, then done=1. Re-arm from DONE -> done clears and busy=1 at the arm edge. Changing last_addr after arm has no effect.
- Async reset: rst driven low mid-PLAY between clock edges -> all outputs 0 and state=IDLE immediately, before the next edge. After release, no valid words appear until arm followed by trigger.
